// File: rtl/corelet_ctrl_if.sv
// Control/handshake bundle between the corelet sequencer and its datapath
// (SRAMs, L0, MAC array, OFIFO, SFU).
interface corelet_ctrl_if #(
    parameter int unsigned addr_bw = 11
);
    logic               start;
    logic               relu_en;
    logic               busy;
    logic               done;
    logic               w_cen_n;
    logic [addr_bw-1:0] w_addr;
    logic               a_cen_n;
    logic [addr_bw-1:0] a_addr;
    logic               l0_wr;
    logic               l0_rd;
    logic               l0_full;
    logic               l0_ready;
    logic [1:0]         inst;
    logic               ofifo_rd;
    logic               ofifo_valid;
    logic               accumulate;
    logic               relu;
    logic               send_output;
    logic [3:0]         pass_idx;

    modport master (
        input  start, relu_en, l0_full, l0_ready, ofifo_valid,
        output busy, done, w_cen_n, w_addr, a_cen_n, a_addr, l0_wr, l0_rd,
               inst, ofifo_rd, accumulate, relu, send_output, pass_idx
    );

    modport slave (
        output start, relu_en, l0_full, l0_ready, ofifo_valid,
        input  busy, done, w_cen_n, w_addr, a_cen_n, a_addr, l0_wr, l0_rd,
               inst, ofifo_rd, accumulate, relu, send_output, pass_idx
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: per pass, load kernel weights into the array, stream
// activations, then drain the OFIFO into the SFU; done after the last pass.
module corelet_ctrl #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned npass   = 9,
    parameter int unsigned nact    = 36,
    parameter int unsigned addr_bw = 11
) (
    input logic            clk,
    input logic            reset,
    corelet_ctrl_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WLOAD     = 3'd1;
    localparam logic [2:0] EXEC      = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;
    localparam logic [2:0] OUT_FLUSH = 3'd4;

    localparam int unsigned CMAX = (nact > col) ? nact : col;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned SW   = $clog2(row + col + 1);

    logic [2:0]    state;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] pop_cnt;
    logic [SW-1:0] skew_cnt;
    logic [3:0]    pass_idx;
    logic          relu_q;
    logic          rd_q;
    logic          send_q;
    logic          done_q;

    logic [CW-1:0] issue_lim;
    logic          issue;
    logic          l0_pop;
    logic          of_pop;
    logic          last_pass;

    assign last_pass = (pass_idx == 4'(npass - 1));

    always_comb begin
        issue_lim = (state == WLOAD) ? CW'(col) : CW'(nact);
        issue     = !bus.l0_full && ((state == WLOAD) || (state == EXEC))
                    && (issue_cnt < issue_lim);
        l0_pop    = bus.l0_ready
                    && (((state == WLOAD) && (pop_cnt < CW'(col)))
                     || ((state == EXEC)  && (pop_cnt < CW'(nact))));
        of_pop    = (state == DRAIN) && bus.ofifo_valid && (pop_cnt < CW'(nact));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            skew_cnt  <= '0;
            pass_idx  <= '0;
            relu_q    <= 1'b0;
            rd_q      <= 1'b0;
            send_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // rd_q tracks the SRAM's one-cycle read latency, so the last
            // issued read still lands in L0 after a state change.
            rd_q   <= issue;
            send_q <= of_pop && last_pass;
            done_q <= (state == OUT_FLUSH);
            if (issue) issue_cnt <= issue_cnt + 1'b1;
            if (l0_pop || of_pop) pop_cnt <= pop_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= WLOAD;
                        pass_idx  <= '0;
                        relu_q    <= bus.relu_en;
                        issue_cnt <= '0;
                        pop_cnt   <= '0;
                        skew_cnt  <= '0;
                    end
                end
                WLOAD: begin
                    // all col weights popped: hold row+col cycles for array skew
                    if (pop_cnt == CW'(col)) begin
                        if (skew_cnt == SW'(row + col - 1)) begin
                            state     <= EXEC;
                            issue_cnt <= '0;
                            pop_cnt   <= '0;
                            skew_cnt  <= '0;
                        end else begin
                            skew_cnt <= skew_cnt + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (l0_pop && (pop_cnt == CW'(nact - 1))) begin
                        state     <= DRAIN;
                        issue_cnt <= '0;
                        pop_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (of_pop && (pop_cnt == CW'(nact - 1))) begin
                        pop_cnt <= '0;
                        if (last_pass) begin
                            state <= OUT_FLUSH;
                        end else begin
                            pass_idx <= pass_idx + 4'd1;
                            state    <= WLOAD;
                        end
                    end
                end
                OUT_FLUSH: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.w_cen_n     = !(issue && (state == WLOAD));
    assign bus.a_cen_n     = !(issue && (state == EXEC));
    assign bus.w_addr      = (state == WLOAD)
                             ? addr_bw'(pass_idx) * addr_bw'(col) + addr_bw'(issue_cnt)
                             : '0;
    assign bus.a_addr      = (state == EXEC)
                             ? addr_bw'(pass_idx) * addr_bw'(nact) + addr_bw'(issue_cnt)
                             : '0;
    assign bus.l0_wr       = rd_q;
    assign bus.l0_rd       = l0_pop;
    assign bus.inst        = (state == WLOAD) ? 2'b01
                           : ((state == EXEC) || (state == DRAIN)) ? 2'b10 : 2'b00;
    assign bus.ofifo_rd    = of_pop;
    assign bus.accumulate  = (state == DRAIN) && (pass_idx != 4'd0);
    assign bus.relu        = relu_q && last_pass && ((state == DRAIN) || (state == OUT_FLUSH));
    assign bus.send_output = send_q;
    assign bus.pass_idx    = pass_idx;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomized bench for corelet_ctrl: L0/OFIFO environment models plus a
// phase-level reference model checked every cycle, and per-tile literal pins.
module tb_corelet_ctrl;
    localparam int ROW = 8, COL = 8, NPASS = 3, NACT = 4, ABW = 4;
    localparam int PH_IDLE = 0, PH_WL = 1, PH_SK = 2, PH_EX = 3, PH_DR = 4, PH_FL = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    corelet_ctrl_if #(.addr_bw(ABW)) bus ();

    corelet_ctrl #(.row(ROW), .col(COL), .npass(NPASS), .nact(NACT), .addr_bw(ABW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, errors = 0;
    // stimulus controls
    logic nxt_reset, nxt_start, nxt_relu, tog;
    int   full_mode, of_mode, force_full, forced_now, stall_arm;
    int   l0_cnt;
    // reference model
    int m_ph, m_pass, m_iss, m_pop, m_skew, m_relu, m_rdprev, m_ofprev, m_done;
    // per-tile observations
    int n_w, n_a, n_wr, n_of, n_send, n_done, n_relu, stall_a;
    int w_seen[$];
    int a_seen[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        n_w = 0; n_a = 0; n_wr = 0; n_of = 0; n_send = 0; n_done = 0; n_relu = 0; stall_a = 0;
        w_seen.delete();
        a_seen.delete();
    endtask

    task automatic compare_and_advance();
        int last, e_issue, e_wrd, e_ard, e_l0rd, e_ofrd, e_inst;
        last    = int'(m_pass == NPASS - 1);
        e_issue = int'(!bus.l0_full && ((m_ph == PH_WL && m_iss < COL) || (m_ph == PH_EX && m_iss < NACT)));
        e_wrd   = int'(e_issue != 0 && m_ph == PH_WL);
        e_ard   = int'(e_issue != 0 && m_ph == PH_EX);
        e_l0rd  = int'(bus.l0_ready && ((m_ph == PH_WL && m_pop < COL) || m_ph == PH_EX));
        e_ofrd  = int'(m_ph == PH_DR && bus.ofifo_valid);
        e_inst  = (m_ph == PH_WL || m_ph == PH_SK) ? 1 : (m_ph == PH_EX || m_ph == PH_DR) ? 2 : 0;

        chk("busy", int'(bus.busy), int'(m_ph != PH_IDLE));
        chk("done", int'(bus.done), m_done);
        chk("w_cen_n", int'(bus.w_cen_n), int'(e_wrd == 0));
        chk("a_cen_n", int'(bus.a_cen_n), int'(e_ard == 0));
        if (e_wrd != 0 || m_ph == PH_IDLE)
            chk("w_addr", int'(bus.w_addr), e_wrd != 0 ? (m_pass * COL + m_iss) % (1 << ABW) : 0);
        if (e_ard != 0 || m_ph == PH_IDLE)
            chk("a_addr", int'(bus.a_addr), e_ard != 0 ? (m_pass * NACT + m_iss) % (1 << ABW) : 0);
        chk("l0_wr", int'(bus.l0_wr), m_rdprev);
        chk("l0_rd", int'(bus.l0_rd), e_l0rd);
        if (m_ph != PH_FL) chk("inst", int'(bus.inst), e_inst);
        chk("ofifo_rd", int'(bus.ofifo_rd), e_ofrd);
        chk("accumulate", int'(bus.accumulate), int'(m_ph == PH_DR && m_pass > 0));
        if (m_ph != PH_FL) chk("relu", int'(bus.relu), int'(m_ph == PH_DR && last != 0 && m_relu != 0));
        chk("send_output", int'(bus.send_output), m_ofprev);
        chk("pass_idx", int'(bus.pass_idx), m_pass);

        n_w    += int'(!bus.w_cen_n);
        n_a    += int'(!bus.a_cen_n);
        n_wr   += int'(bus.l0_wr);
        n_of   += int'(bus.ofifo_rd);
        n_send += int'(bus.send_output);
        n_done += int'(bus.done);
        n_relu += int'(bus.ofifo_rd && bus.relu);
        if (forced_now != 0) stall_a += int'(!bus.a_cen_n);
        if (!bus.w_cen_n) w_seen.push_back(int'(bus.w_addr));
        if (!bus.a_cen_n) a_seen.push_back(int'(bus.a_addr));

        if (!reset) begin
            m_ph = PH_IDLE; m_pass = 0; m_iss = 0; m_pop = 0; m_skew = 0;
            m_relu = 0; m_rdprev = 0; m_ofprev = 0; m_done = 0;
            l0_cnt = 0;
        end else begin
            l0_cnt   = l0_cnt + int'(bus.l0_wr) - int'(bus.l0_rd);
            m_rdprev = e_issue;
            m_ofprev = int'(e_ofrd != 0 && last != 0);
            m_done   = int'(m_ph == PH_FL);
            if (e_issue != 0) m_iss++;
            if (e_l0rd != 0 || e_ofrd != 0) m_pop++;
            case (m_ph)
                PH_IDLE: if (bus.start) begin
                    m_ph = PH_WL; m_pass = 0; m_relu = int'(bus.relu_en); m_iss = 0; m_pop = 0;
                end
                PH_WL: if (m_pop == COL) begin m_ph = PH_SK; m_skew = 0; end
                PH_SK: begin
                    m_skew++;
                    if (m_skew == ROW + COL) begin m_ph = PH_EX; m_iss = 0; m_pop = 0; end
                end
                PH_EX: if (m_pop == NACT) begin m_ph = PH_DR; m_iss = 0; m_pop = 0; end
                PH_DR: if (m_pop == NACT) begin
                    m_pop = 0;
                    if (last != 0) m_ph = PH_FL;
                    else begin m_pass++; m_ph = PH_WL; end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset         = nxt_reset;
        bus.start     = nxt_start;
        bus.relu_en   = nxt_relu;
        bus.l0_ready  = (l0_cnt > 0);
        forced_now    = int'(force_full > 0);
        bus.l0_full   = (force_full > 0) || (full_mode != 0 && $urandom_range(3) == 0);
        if (force_full > 0) force_full--;
        tog = ~tog;
        case (of_mode)
            0:       bus.ofifo_valid = 1'b1;
            1:       bus.ofifo_valid = tog;
            default: bus.ofifo_valid = 1'($urandom_range(1));
        endcase
        @(negedge clk);
        compare_and_advance();
    endtask

    task automatic run_tile(input string tag, input logic relu, input int fm, input int om,
                            input int stall, input int start_busy);
        int seen;
        clear_obs();
        full_mode = fm; of_mode = om; stall_arm = stall;
        nxt_relu = relu; nxt_start = 1'b1;
        step();
        nxt_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 800 && seen == 0; i++) begin
            nxt_relu  = 1'($urandom_range(1));
            nxt_start = (start_busy != 0 && (i == 20 || i == 21));
            step();
            if (stall_arm != 0 && !bus.a_cen_n) begin
                force_full = 10;
                stall_arm  = 0;
            end
            if (bus.done) seen = 1;
        end
        nxt_start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        for (int i = 0; i < 3; i++) step();
        chk({tag, "_w_reads"}, n_w, 24);
        chk({tag, "_a_reads"}, n_a, 12);
        chk({tag, "_l0_wr"}, n_wr, 36);
        chk({tag, "_ofifo_pops"}, n_of, 12);
        chk({tag, "_send_pulses"}, n_send, 4);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_relu_pops"}, n_relu, relu ? 4 : 0);
        chk({tag, "_final_pass"}, int'(bus.pass_idx), 2);
        chk({tag, "_w_first"}, w_seen.size() > 0 ? w_seen[0] : -1, 0);
        chk({tag, "_w_wrap"}, w_seen.size() > 16 ? w_seen[16] : -1, 0);
        chk({tag, "_w_last"}, w_seen.size() > 23 ? w_seen[23] : -1, 7);
        chk({tag, "_a_first"}, a_seen.size() > 0 ? a_seen[0] : -1, 0);
        chk({tag, "_a_pass1"}, a_seen.size() > 4 ? a_seen[4] : -1, 4);
        chk({tag, "_a_last"}, a_seen.size() > 11 ? a_seen[11] : -1, 11);
        if (stall != 0) chk({tag, "_a_during_stall"}, stall_a, 0);
    endtask

    initial begin
        int reached;
        nxt_reset = 1'b0; nxt_start = 1'b0; nxt_relu = 1'b0; tog = 1'b0;
        full_mode = 0; of_mode = 0; force_full = 0; forced_now = 0; stall_arm = 0; l0_cnt = 0;
        reset = 1'b0; bus.start = 1'b0; bus.relu_en = 1'b0;
        bus.l0_full = 1'b0; bus.l0_ready = 1'b0; bus.ofifo_valid = 1'b0;
        m_ph = PH_IDLE; m_pass = 0; m_iss = 0; m_pop = 0; m_skew = 0;
        m_relu = 0; m_rdprev = 0; m_ofprev = 0; m_done = 0;
        clear_obs();

        // reset with a coincident start: reset must win
        step();
        nxt_start = 1'b1;
        step();
        nxt_start = 1'b0;
        step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_w_cen_n", int'(bus.w_cen_n), 1);
        chk("rst_a_cen_n", int'(bus.a_cen_n), 1);
        chk("rst_inst", int'(bus.inst), 0);
        nxt_reset = 1'b1;
        step();
        step();
        chk("post_rst_busy", int'(bus.busy), 0);

        run_tile("idealA", 1'b1, 0, 0, 0, 1);
        run_tile("stallB", 1'b0, 0, 1, 1, 0);

        // abort mid-EXEC with a 3-cycle reset
        full_mode = 1; of_mode = 2; nxt_relu = 1'b1; nxt_start = 1'b1;
        step();
        nxt_start = 1'b0;
        reached = 0;
        for (int i = 0; i < 400 && reached == 0; i++) begin
            step();
            if (bus.inst == 2'b10) reached = 1;
        end
        chk("abort_reached_exec", reached, 1);
        step();
        clear_obs();
        nxt_reset = 1'b0;
        step();
        step();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_w_cen_n", int'(bus.w_cen_n), 1);
        chk("abort_a_cen_n", int'(bus.a_cen_n), 1);
        chk("abort_l0_wr", int'(bus.l0_wr), 0);
        chk("abort_inst", int'(bus.inst), 0);
        chk("abort_pass_idx", int'(bus.pass_idx), 0);
        step();
        nxt_reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("abort_no_done", n_done, 0);

        run_tile("randC", 1'($urandom_range(1)), 1, 2, 0, 1);
        run_tile("randD", 1'b1, 1, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
